lfsr_monitor: RTL and testbench
===============================

LFSR_MONITOR -- requirements
Module: lfsr_monitor

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: q_in  in  16  sample stream from the lfsr16 q output, one new value per clk.
REQ-004 SHALL have: start  in  1  begin measurement; sampled in IDLE, DONE and ERR only.
REQ-005 SHALL have: busy  out  1  high while state is COUNT.
REQ-006 SHALL have: done  out  1  high while state is DONE.
REQ-007 SHALL have: err  out  1  high while state is ERR.
REQ-008 SHALL have: err_code  out  2  00 none, 01 zero lock-up, 10 stuck, 11 timeout.
REQ-009 SHALL have: period  out  16  measured sequence period, valid while done=1.
REQ-010 SHALL have: ones_cnt  out  16  count of samples with q_in[0]=1 during COUNT.

Function
REQ-011 SHALL implement states IDLE, COUNT, DONE and ERR, with outputs registered and decoded from state only.
REQ-012 On a rising edge in IDLE, DONE or ERR with start=1: seed<=q_in, prev<=q_in, cnt<=0, period<=0, ones_cnt<=0, err_code<=00, state<=COUNT.
REQ-013 On each edge in COUNT: prev<=q_in and cnt<=cnt+1, then evaluate in priority order zero > stuck > match > timeout.
REQ-014 zero: q_in==16'h0000 -> state ERR, err_code 01.
REQ-015 stuck: q_in==prev -> state ERR, err_code 10.
REQ-016 match: q_in==seed -> state DONE, period<=cnt+1; a match requiring 65535 steps SHALL give period 16'hFFFF.
REQ-017 timeout: no match and cnt+1==16'hFFFF -> state ERR, err_code 11; cnt SHALL never wrap.
REQ-018 start SHALL be ignored while in COUNT.
REQ-019 DONE and ERR SHALL hold their outputs until start=1 (restart per REQ-012) or reset.
REQ-020 A seed of 16'h0000 captured at start SHALL produce the zero error on the first COUNT edge.
REQ-021 Latency: done or err rises one clk after the edge that sees the terminating q_in; no combinational path from q_in to any output.

Reset
REQ-022 reset=1 SHALL immediately force state IDLE, busy=0, done=0, err=0, err_code=00, period=0, ones_cnt=0, seed=0, prev=0 and cnt=0, including mid-COUNT.
REQ-023 After reset deasserts, the block SHALL stay in IDLE until start=1.

Configuration
REQ-024 Macro LFSR_MONITOR_ONES_EN defined: ones_cnt SHALL increment, saturating at 16'hFFFF, on each COUNT edge where q_in[0]=1, and hold its value in DONE/ERR.
REQ-025 Macro LFSR_MONITOR_ONES_EN undefined: ones_cnt SHALL be constant 0, no counter logic SHALL be present, and all other behaviour SHALL be unchanged.

Verification
REQ-026 Reset: assert reset for 20 ns with start=1 -> all outputs 0, state IDLE; after deassert with start=0, no change for 100 cycles.
REQ-027 Maximal period: connect lfsr16 and pulse start 2 cycles after reset release -> busy for 65535 cycles, then done=1, period=16'hFFFF, err=0; with LFSR_MONITOR_ONES_EN, ones_cnt=32768.
REQ-028 Short sequence: bench drives repeating 1,2,3,4,5 and pulses start on value 3 -> done=1 with period=5 exactly 5 edges after capture.
REQ-029 Faults: drive 7,9,0 -> err_code=01; drive 7,9,9 -> err_code=10; drive 0,1,1 -> err_code=01 (priority); drive an incrementing count from 1 -> err_code=11 after 65535 COUNT edges.
REQ-030 Reset mid-COUNT at cycle 1000 -> busy=0 immediately; start re-pulsed afterward -> measurement completes with correct period; start pulses during COUNT -> no effect on the result.

Source files
------------

// File: rtl/lfsr_monitor.sv
// lfsr_monitor: measures the period of a 16-bit LFSR sample stream and flags lock-up faults
//
// Ports:
//   clk      in   1  sole clock, rising edge
//   reset    in   1  asynchronous active-high reset
//   q_in     in  16  sample stream, one new value per clk
//   start    in   1  begin measurement (honoured in IDLE, DONE, ERR only)
//   busy     out  1  state is COUNT
//   done     out  1  state is DONE
//   err      out  1  state is ERR
//   err_code out  2  00 none, 01 zero lock-up, 10 stuck, 11 timeout
//   period   out 16  measured period, valid while done=1
//   ones_cnt out 16  samples with q_in[0]=1 during COUNT
//
// Build option: define LFSR_MONITOR_ONES_EN to enable the ones counter;
// otherwise ones_cnt is tied to zero.
`timescale 1ns/1ps
module lfsr_monitor (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] q_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] period,
    output logic [15:0] ones_cnt
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE, ERR} state_t;
    state_t      state;
    logic [15:0] seed, prev, cnt, cnt_nx;
    assign cnt_nx = cnt + 16'd1;
    assign busy = (state == COUNT);
    assign done = (state == DONE);
    assign err  = (state == ERR);
    // A zero seed can never be matched by a healthy LFSR, so it is reported
    // as a zero lock-up on the first COUNT edge. cnt stops at 16'hFFFF because
    // either a match or the timeout ends COUNT on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            seed     <= 16'h0;
            prev     <= 16'h0;
            cnt      <= 16'h0;
            period   <= 16'h0;
            err_code <= 2'b00;
        end else if (state == COUNT) begin
            prev <= q_in;
            cnt  <= cnt_nx;
            if (q_in == 16'h0 || seed == 16'h0) begin
                state    <= ERR;
                err_code <= 2'b01;
            end else if (q_in == prev) begin
                state    <= ERR;
                err_code <= 2'b10;
            end else if (q_in == seed) begin
                state  <= DONE;
                period <= cnt_nx;
            end else if (cnt_nx == 16'hFFFF) begin
                state    <= ERR;
                err_code <= 2'b11;
            end
        end else if (start) begin
            state    <= COUNT;
            seed     <= q_in;
            prev     <= q_in;
            cnt      <= 16'h0;
            period   <= 16'h0;
            err_code <= 2'b00;
        end
    end
`ifdef LFSR_MONITOR_ONES_EN
    logic [15:0] ones_r;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ones_r <= 16'h0;
        else if (state != COUNT && start)
            ones_r <= 16'h0;
        else if (state == COUNT && q_in[0] && ones_r != 16'hFFFF)
            ones_r <= ones_r + 16'd1;
    end
    assign ones_cnt = ones_r;
`else
    assign ones_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_lfsr_monitor.sv
// tb_lfsr_monitor: directed self-checking bench for lfsr_monitor
`timescale 1ns/1ps
module tb_lfsr_monitor;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] q_in = 16'h0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] period, ones_cnt;
    int nvec = 0, nerr = 0;
`ifdef LFSR_MONITOR_ONES_EN
    localparam logic [15:0] EXP_ONES = 16'd32768;
`else
    localparam logic [15:0] EXP_ONES = 16'd0;
`endif

    lfsr_monitor dut (
        .clk(clk), .reset(reset), .q_in(q_in), .start(start),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .period(period), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic drive(input logic [15:0] v, input logic s);
        @(negedge clk);
        q_in = v;
        start = s;
    endtask

    // {busy,done,err,err_code}
    task automatic test_reset;
        reset = 1'b1; start = 1'b1; q_in = 16'h5;
        #20;
        nvec++;
        if ({busy, done, err, err_code, period, ones_cnt} !== 37'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got b=%b d=%b e=%b c=%b p=%h o=%h want all 0", busy, done, err, err_code, period, ones_cnt);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            q_in = q_in + 16'd3;
            nvec++;
            if ({busy, done, err, err_code, period} !== 21'h0) begin
                nerr++;
                $display("FAIL idle_hold[%0d]: got b=%b d=%b e=%b c=%b p=%h want idle", i, busy, done, err, err_code, period);
            end
        end
    endtask

    task automatic test_short(input logic spurious_start);
        drive(16'd1, 1'b0); drive(16'd2, 1'b0); drive(16'd3, 1'b1);
        drive(16'd4, 1'b0);
        nvec++;
        if ({busy, done, err, err_code} !== 5'b10000) begin
            nerr++;
            $display("FAIL short_busy: got %b want 10000", {busy, done, err, err_code});
        end
        drive(16'd5, spurious_start); drive(16'd1, spurious_start); drive(16'd2, 1'b0);
        drive(16'd3, 1'b0);
        nvec++;
        if ({busy, done} !== 2'b10) begin
            nerr++;
            $display("FAIL short_early: got b=%b d=%b want b=1 d=0", busy, done);
        end
        drive(16'd4, 1'b0);
        nvec++;
        if ({busy, done, err, err_code, period} !== {5'b01000, 16'd5}) begin
            nerr++;
            $display("FAIL short_done: got %b p=%0d want 01000 p=5", {busy, done, err, err_code}, period);
        end
        drive(16'd5, 1'b0); drive(16'd9, 1'b0); drive(16'd9, 1'b0);
        nvec++;
        if ({done, period} !== {1'b1, 16'd5}) begin
            nerr++;
            $display("FAIL short_hold: got d=%b p=%0d want d=1 p=5", done, period);
        end
    endtask

    task automatic test_faults;
        drive(16'd7, 1'b1); drive(16'd9, 1'b0); drive(16'd0, 1'b0);
        @(negedge clk);
        nvec++;
        if ({busy, done, err, err_code} !== 5'b00101) begin
            nerr++;
            $display("FAIL fault_zero: got %b want 00101", {busy, done, err, err_code});
        end
        drive(16'd7, 1'b1); drive(16'd9, 1'b0);
        nvec++;
        if ({busy, done, err, err_code} !== 5'b10000) begin
            nerr++;
            $display("FAIL restart_from_err: got %b want 10000", {busy, done, err, err_code});
        end
        drive(16'd9, 1'b0);
        @(negedge clk);
        nvec++;
        if ({busy, done, err, err_code} !== 5'b00110) begin
            nerr++;
            $display("FAIL fault_stuck: got %b want 00110", {busy, done, err, err_code});
        end
        drive(16'd0, 1'b1); drive(16'd1, 1'b0); drive(16'd1, 1'b0);
        nvec++;
        if ({busy, done, err, err_code} !== 5'b00101) begin
            nerr++;
            $display("FAIL fault_zero_seed: got %b want 00101", {busy, done, err, err_code});
        end
        drive(16'd4, 1'b0); drive(16'd4, 1'b0);
        nvec++;
        if ({err, err_code} !== 3'b101) begin
            nerr++;
            $display("FAIL err_hold: got e=%b c=%b want e=1 c=01", err, err_code);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] x;
        x = 16'hACE1;
        drive(x, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            x = lfsr_next(x);
            drive(x, 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        nvec++;
        if ({busy, done, err, err_code, period, ones_cnt} !== 37'h0) begin
            nerr++;
            $display("FAIL reset_mid: got b=%b d=%b e=%b c=%b p=%h o=%h want all 0", busy, done, err, err_code, period, ones_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        test_short(1'b1);
    endtask

    task automatic test_max_period;
        logic [15:0] x;
        int n;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        x = 16'h0001;
        drive(x, 1'b0);
        x = lfsr_next(x); drive(x, 1'b0);
        x = lfsr_next(x); drive(x, 1'b1);
        x = lfsr_next(x); drive(x, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 70000) begin
            n++;
            x = lfsr_next(x);
            drive(x, 1'b0);
        end
        nvec++;
        if (n != 65535) begin
            nerr++;
            $display("FAIL max_busy_cycles: got %0d want 65535", n);
        end
        nvec++;
        if ({busy, done, err, err_code, period} !== {5'b01000, 16'hFFFF}) begin
            nerr++;
            $display("FAIL max_done: got %b p=%h want 01000 p=ffff", {busy, done, err, err_code}, period);
        end
        nvec++;
        if (ones_cnt !== EXP_ONES) begin
            nerr++;
            $display("FAIL max_ones: got %0d want %0d", ones_cnt, EXP_ONES);
        end
    endtask

    task automatic test_timeout;
        logic [15:0] v;
        int n;
        drive(16'd1, 1'b1);
        v = 16'd2;
        drive(v, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 70000) begin
            n++;
            v = (v == 16'hFFFF) ? 16'd2 : v + 16'd1;
            drive(v, 1'b0);
        end
        nvec++;
        if (n != 65535) begin
            nerr++;
            $display("FAIL timeout_cycles: got %0d want 65535", n);
        end
        nvec++;
        if ({busy, done, err, err_code, period} !== {5'b00111, 16'h0}) begin
            nerr++;
            $display("FAIL timeout_err: got %b p=%h want 00111 p=0", {busy, done, err, err_code}, period);
        end
    endtask

    initial begin
        test_reset;
        test_short(1'b0);
        test_faults;
        test_reset_mid;
        test_max_period;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
